// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request size codes, memory write
// codes and the controller state encoding.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    localparam logic [1:0] WR_NONE = 2'd0;
    localparam logic [1:0] WR_BYTE = 2'd1;
    localparam logic [1:0] WR_HALF = 2'd2;
    localparam logic [1:0] WR_WORD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_RELEASE,
        ST_LOAD_WAIT,
        ST_RESP
    } lsu_state_t;

    function automatic logic [1:0] size_to_wr(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_wr = WR_BYTE;
            SZ_HALF: size_to_wr = WR_HALF;
            SZ_WORD: size_to_wr = WR_WORD;
            default: size_to_wr = WR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signals of the load/store unit.
// slave = the LSU itself; master = execute stage plus byte_addressable memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [1:0]  mem_write;
    logic [7:0]  mem_d0, mem_d1, mem_d2, mem_d3;
    logic        mem_error;
    logic        mem_done;
    logic [7:0]  mem_q0, mem_q1, mem_q2, mem_q3;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        input  mem_error, mem_done, mem_q0, mem_q1, mem_q2, mem_q3,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_write, mem_d0, mem_d1, mem_d2, mem_d3
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        output mem_error, mem_done, mem_q0, mem_q1, mem_q2, mem_q3,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_write, mem_d0, mem_d1, mem_d2, mem_d3
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load-data extraction: selects byte/half/word from the read
// lanes (q0 most significant) and sign- or zero-extends to 32 bits.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [7:0]  i_q0,
    input  logic [7:0]  i_q1,
    input  logic [7:0]  i_q2,
    input  logic [7:0]  i_q3,
    output logic [31:0] o_result
);
    logic w_fill;

    assign w_fill = i_signed & i_q0[7];

    always_comb begin
        o_result = {i_q0, i_q1, i_q2, i_q3};
        case (i_size)
            SZ_BYTE: o_result = {{24{w_fill}}, i_q0};
            SZ_HALF: o_result = {{16{w_fill}}, i_q0, i_q1};
            default: o_result = {i_q0, i_q1, i_q2, i_q3};
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of byte_addressable: one request at a time, store
// write/done handshake, load latency wait. Optional watchdog: LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    lsu_state_t  r_state, w_state_next;
    logic        r_req_ready, w_req_ready_next;
    logic        r_resp_valid, w_resp_valid_next;
    logic [31:0] r_resp_rdata, w_resp_rdata_next;
    logic        r_resp_fault, w_resp_fault_next;
    logic [31:0] r_mem_address, w_mem_address_next;
    logic [1:0]  r_mem_write, w_mem_write_next;
    logic [31:0] r_mem_lanes, w_mem_lanes_next;
    logic [1:0]  r_size, w_size_next;
    logic        r_signed, w_signed_next;
    logic        r_fault, w_fault_next;
    logic [31:0] r_load_data, w_load_data_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic [31:0] w_ext_data;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wd, w_wd_next;
    logic       w_wd_expired;

    assign w_wd_expired = (r_wd == WD_LAST);
    // Restarts on every state change, so STORE and RELEASE each get a full budget.
    assign w_wd_next = (w_state_next != r_state ||
                        (r_state != ST_STORE && r_state != ST_RELEASE)) ? 8'd0 : r_wd + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wd <= 8'd0;
        else        r_wd <= w_wd_next;
    end
`endif

    lsu_load_extend u_load_extend (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_q0     (bus.mem_q0),
        .i_q1     (bus.mem_q1),
        .i_q2     (bus.mem_q2),
        .i_q3     (bus.mem_q3),
        .o_result (w_ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_fault  <= 1'b0;
            r_mem_address <= '0;
            r_mem_write   <= WR_NONE;
            r_mem_lanes   <= '0;
            r_size        <= SZ_BYTE;
            r_signed      <= 1'b0;
            r_fault       <= 1'b0;
            r_load_data   <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_req_ready   <= w_req_ready_next;
            r_resp_valid  <= w_resp_valid_next;
            r_resp_rdata  <= w_resp_rdata_next;
            r_resp_fault  <= w_resp_fault_next;
            r_mem_address <= w_mem_address_next;
            r_mem_write   <= w_mem_write_next;
            r_mem_lanes   <= w_mem_lanes_next;
            r_size        <= w_size_next;
            r_signed      <= w_signed_next;
            r_fault       <= w_fault_next;
            r_load_data   <= w_load_data_next;
            r_cnt         <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_resp_valid_next  = 1'b0;
        w_resp_rdata_next  = '0;
        w_resp_fault_next  = 1'b0;
        w_mem_address_next = r_mem_address;
        w_mem_write_next   = r_mem_write;
        w_mem_lanes_next   = r_mem_lanes;
        w_size_next        = r_size;
        w_signed_next      = r_signed;
        w_fault_next       = r_fault;
        w_load_data_next   = r_load_data;
        w_cnt_next         = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_size_next      = bus.req_size;
                    w_signed_next    = bus.req_signed;
                    w_fault_next     = 1'b0;
                    w_load_data_next = '0;
                    if (bus.req_addr[1:0] != 2'b00 || bus.req_size == SZ_ILLEGAL) begin
                        w_fault_next = 1'b1;
                        w_state_next = ST_RESP;
                    end else if (bus.req_store) begin
                        w_state_next       = ST_STORE;
                        w_mem_address_next = bus.req_addr;
                        w_mem_write_next   = size_to_wr(bus.req_size);
                        case (bus.req_size)
                            SZ_BYTE: w_mem_lanes_next = {bus.req_wdata[7:0], 24'h0};
                            SZ_HALF: w_mem_lanes_next = {bus.req_wdata[15:0], 16'h0};
                            default: w_mem_lanes_next = bus.req_wdata;
                        endcase
                    end else begin
                        w_state_next       = ST_LOAD_WAIT;
                        w_mem_address_next = bus.req_addr;
                        w_mem_write_next   = WR_NONE;
                        w_cnt_next         = LAT;
                    end
                end
            end
            ST_STORE: begin
                if (bus.mem_error) w_fault_next = 1'b1;
                // An error ends the write just like done; release still waits for done low.
                if (bus.mem_done || bus.mem_error) begin
                    w_mem_write_next = WR_NONE;
                    w_state_next     = ST_RELEASE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (w_wd_expired) begin
                    w_mem_write_next = WR_NONE;
                    w_fault_next     = 1'b1;
                    w_state_next     = ST_RESP;
                end
`endif
            end
            ST_RELEASE: begin
                if (!bus.mem_done) w_state_next = ST_RESP;
`ifdef LSU_TIMEOUT_EN
                else if (w_wd_expired) begin
                    w_fault_next = 1'b1;
                    w_state_next = ST_RESP;
                end
`endif
            end
            ST_LOAD_WAIT: begin
                if (bus.mem_error) w_fault_next = 1'b1;
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_load_data_next = w_ext_data;
                    w_state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid_next = 1'b1;
                w_resp_fault_next = r_fault;
                w_resp_rdata_next = r_fault ? 32'h0 : r_load_data;
                w_state_next      = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_req_ready_next = (w_state_next == ST_IDLE);

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_fault  = r_resp_fault;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_d0      = r_mem_lanes[31:24];
    assign bus.mem_d1      = r_mem_lanes[23:16];
    assign bus.mem_d2      = r_mem_lanes[15:8];
    assign bus.mem_d3      = r_mem_lanes[7:0];
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small memory model and a response
// scoreboard. Define LSU_TIMEOUT_EN to also exercise the store watchdog.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int RL = 2;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_count = 0;
    exp_t sb[$];

    // Memory model state
    bit          done_en = 1'b1;
    logic [31:0] model_q = 32'h0;
    int          age = 0;
    int          d_cnt = 0;
    int          rel_cnt = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [1:0]  prev_write = 2'd0;
    bit          saw_write = 1'b0;
    bit          early_drop = 1'b0;
    bit          bad_rewrite = 1'b0;
    logic [1:0]  cap_write = 2'd0;
    logic [31:0] cap_data = 32'h0;
    logic [31:0] cap_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.resp_valid) resp_count++;

    // Store handshake: done rises 2 cycles into a write, falls 2 cycles after
    // write is dropped. Read lanes show real data only once the address has
    // been stable (no write) for RL cycles, otherwise a filler pattern.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_done = 1'b0;
            d_cnt = 0;
            rel_cnt = 0;
        end else if (bus.mem_write != 2'd0) begin
            saw_write = 1'b1;
            if (rel_cnt > 0) bad_rewrite = 1'b1;
            if (done_en && !bus.mem_done) begin
                d_cnt++;
                if (d_cnt >= 2) begin
                    bus.mem_done = 1'b1;
                    cap_write = bus.mem_write;
                    cap_data  = {bus.mem_d0, bus.mem_d1, bus.mem_d2, bus.mem_d3};
                    cap_addr  = bus.mem_address;
                end
            end
        end else begin
            if (prev_write != 2'd0 && !bus.mem_done) early_drop = 1'b1;
            d_cnt = 0;
            if (bus.mem_done) begin
                rel_cnt++;
                if (rel_cnt >= 2) begin
                    bus.mem_done = 1'b0;
                    rel_cnt = 0;
                end
            end
        end
        age = (bus.mem_write == 2'd0 && bus.mem_address == prev_addr) ? age + 1 : 1;
        prev_addr  = bus.mem_address;
        prev_write = bus.mem_write;
        {bus.mem_q0, bus.mem_q1, bus.mem_q2, bus.mem_q3} = (age >= RL) ? model_q : 32'hA5A5A5A5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit store, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit expect_resp, input string tag,
                         input logic [31:0] exp_rdata, input bit exp_fault, input int exp_lat);
        exp_t e;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.tag = tag; e.rdata = exp_rdata; e.fault = exp_fault; e.lat = exp_lat; e.acc = cyc;
        if (expect_resp) sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble request fields after acceptance; the unit must have latched them.
        bus.req_valid  = 1'b0;
        bus.req_store  = ~store;
        bus.req_size   = SZ_ILLEGAL;
        bus.req_signed = ~sgn;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h5A5A_5A5A;
    endtask

    task automatic wait_resp();
        exp_t e;
        bit   got = 1'b0;
        int   lat;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed response expected none");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout: observed no resp_valid expected resp_valid within 100 cycles", e.tag);
        end
        if (!got) return;
        lat = cyc - e.acc;
        $display("resp %-10s rdata=0x%08h fault=%0d latency=%0d", e.tag, bus.resp_rdata, bus.resp_fault, lat);
        chk({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.tag, "_fault"}, {31'b0, bus.resp_fault}, {31'b0, e.fault});
        if (e.lat >= 0) chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        @(negedge clk);
        chk({e.tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        int rc;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = SZ_BYTE;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_error = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_resp_fault", {31'b0, bus.resp_fault}, 32'd0);
        chk("rst_mem_addr",   bus.mem_address,         32'd0);
        chk("rst_mem_write",  {30'b0, bus.mem_write},  32'd0);
        chk("rst_mem_lanes",  {bus.mem_d0, bus.mem_d1, bus.mem_d2, bus.mem_d3}, 32'd0);
        rst_n = 1'b1;

        // Word store with full done handshake
        early_drop = 1'b0; bad_rewrite = 1'b0;
        rc = resp_count;
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, "st_word", 32'h0, 1'b0, -1);
        @(negedge clk);
        chk("st_word_write", {30'b0, bus.mem_write}, 32'd3);
        chk("st_word_lanes", {bus.mem_d0, bus.mem_d1, bus.mem_d2, bus.mem_d3}, 32'hDEADBEEF);
        chk("st_word_addr",  bus.mem_address, 32'h10);
        wait_resp();
        chk("st_word_cap_write", {30'b0, cap_write}, 32'd3);
        chk("st_word_cap_data",  cap_data, 32'hDEADBEEF);
        chk("st_word_cap_addr",  cap_addr, 32'h10);
        chk("st_word_early_drop", {31'b0, early_drop}, 32'd0);
        chk("st_word_rewrite",    {31'b0, bad_rewrite}, 32'd0);
        chk("st_word_resp_count", 32'(resp_count - rc), 32'd1);

        // Byte and half stores: lane mapping with unused lanes zero
        issue(1'b1, SZ_BYTE, 1'b0, 32'h44, 32'h123456AB, 1'b1, "st_byte", 32'h0, 1'b0, -1);
        wait_resp();
        chk("st_byte_cap_write", {30'b0, cap_write}, 32'd1);
        chk("st_byte_cap_data",  cap_data, 32'hAB000000);
        issue(1'b1, SZ_HALF, 1'b0, 32'h48, 32'h1234BEEF, 1'b1, "st_half", 32'h0, 1'b0, -1);
        wait_resp();
        chk("st_half_cap_write", {30'b0, cap_write}, 32'd2);
        chk("st_half_cap_data",  cap_data, 32'hBEEF0000);

        // Loads: byte signed/unsigned, half signed both polarities, word
        model_q = 32'h80112233;
        issue(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 1'b1, "ld_sbyte", 32'hFFFFFF80, 1'b0, RL + 2);
        wait_resp();
        issue(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 1'b1, "ld_ubyte", 32'h00000080, 1'b0, RL + 2);
        wait_resp();
        model_q = 32'h12F45566;
        issue(1'b0, SZ_HALF, 1'b1, 32'h24, 32'h0, 1'b1, "ld_half_p", 32'h000012F4, 1'b0, RL + 2);
        wait_resp();
        model_q = 32'h92F45566;
        issue(1'b0, SZ_HALF, 1'b1, 32'h24, 32'h0, 1'b1, "ld_half_n", 32'hFFFF92F4, 1'b0, RL + 2);
        wait_resp();
        model_q = 32'hCAFEF00D;
        issue(1'b0, SZ_WORD, 1'b1, 32'h30, 32'h0, 1'b1, "ld_word", 32'hCAFEF00D, 1'b0, RL + 2);
        wait_resp();

        // Faults: misaligned store and illegal size never touch memory
        saw_write = 1'b0;
        issue(1'b1, SZ_WORD, 1'b0, 32'h13, 32'h11223344, 1'b1, "st_misal", 32'h0, 1'b1, 2);
        wait_resp();
        issue(1'b0, SZ_ILLEGAL, 1'b0, 32'h40, 32'h0, 1'b1, "ld_illegal", 32'h0, 1'b1, 2);
        wait_resp();
        chk("fault_no_write", {31'b0, saw_write}, 32'd0);

        // Reset in the middle of a store: abort silently, then a clean load
        done_en = 1'b0;
        issue(1'b1, SZ_WORD, 1'b0, 32'h50, 32'h0BADF00D, 1'b0, "st_abort", 32'h0, 1'b0, -1);
        repeat (3) @(negedge clk);
        chk("abort_in_store", {30'b0, bus.mem_write}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write_drop", {30'b0, bus.mem_write}, 32'd0);
        chk("abort_ready",      {31'b0, bus.req_ready}, 32'd1);
        chk("abort_no_resp",    {31'b0, bus.resp_valid}, 32'd0);
        rc = resp_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_resp_count", 32'(resp_count - rc), 32'd0);
        done_en = 1'b1;
        model_q = 32'h7F000000;
        issue(1'b0, SZ_BYTE, 1'b1, 32'h60, 32'h0, 1'b1, "ld_after", 32'h0000007F, 1'b0, RL + 2);
        wait_resp();

`ifdef LSU_TIMEOUT_EN
        // Watchdog: memory never completes the store
        done_en = 1'b0;
        issue(1'b1, SZ_WORD, 1'b0, 32'h70, 32'hDEADBEEF, 1'b1, "st_timeout", 32'h0, 1'b1, -1);
        wait_resp();
        chk("timeout_write_drop", {30'b0, bus.mem_write}, 32'd0);
        chk("timeout_ready",      {31'b0, bus.req_ready}, 32'd1);
        done_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed run still active expected $finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Upstream of byte_addressable.
- Accepts one load/store request at a time from the execute stage and converts its size code into the memory's write code and d0..d3 byte lanes.
- Runs the memory's write/done handshake, waits out synchronous-RAM read latency, and returns sign- or zero-extended load data.
- Faults misaligned requests without touching memory.

Parameters:
- READ_LATENCY, 2, cycles from stable mem_address (mem_write=0) to valid mem_q0..q3; legal range 1..7.
- TIMEOUT_CYCLES, 64, store-handshake watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid
- mem_address  out  32  to byte_addressable address
- mem_write  out  2  0=none, 1=byte, 2=half, 3=word
- mem_d0, mem_d1, mem_d2, mem_d3  out  8 each  store lanes; d0 is most significant
- mem_error  in  1  memory misalignment flag
- mem_done  in  1  memory store-complete flag
- mem_q0, mem_q1, mem_q2, mem_q3  in  8 each  read lanes; q0 is most significant

Behaviour:
- All outputs registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_write=0, mem_d0..d3=0.
- Async reset mid-operation aborts to IDLE, dropping mem_write to 0 immediately. The in-flight request gets no response.
- Accept on req_valid && req_ready. All req_* fields are latched; later req changes are ignored.
- Fault check at acceptance: req_addr[1:0]!=0 or req_size==3.
  - IDLE -> RESP with resp_fault=1.
  - mem_write stays 0; no memory access.
- Store lane mapping:
  - byte: mem_write=1, d0=wdata[7:0].
  - half: mem_write=2, d0=wdata[15:8], d1=wdata[7:0].
  - word: mem_write=3, d0..d3=wdata[31:24], [23:16], [15:8], [7:0].
  - Unused lanes are driven 0.
- FSM states: IDLE, STORE, RELEASE, LOAD_WAIT, RESP.
- IDLE -> STORE (store accepted):
  - mem_address and mem_write are set on the same edge.
  - mem_write is held nonzero until mem_done=1 is sampled.
- STORE -> RELEASE:
  - mem_write=0 on the next edge.
  - Remain in RELEASE until mem_done=0 is sampled, so the memory reaches START before the next request.
- RELEASE -> RESP.
- Store fault:
  - mem_error=1 sampled in STORE or LOAD_WAIT sets a sticky fault bit, reported at RESP.
  - In STORE, mem_write is still dropped through RELEASE.
- IDLE -> LOAD_WAIT (load accepted):
  - mem_write=0; 3-bit counter loads READ_LATENCY.
  - Counter decrements each cycle; mem_q is sampled when the count reaches 0.
  - Then -> RESP.
- Load extraction:
  - word = {q0,q1,q2,q3}.
  - half = ext({q0,q1}).
  - byte = ext(q0).
  - ext = replicate the MSB if req_signed, else zero-fill.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE.
  - No backpressure.
  - req_ready returns to 1 the cycle after RESP.
- Throughput: at most one request outstanding.
  - Minimum load turnaround = READ_LATENCY+2 cycles from accept to resp_valid.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent in STORE and in RELEASE; it restarts on entry to each state.
  - Reaching TIMEOUT_CYCLES forces mem_write=0, resp_fault=1, and a transition to RESP.
- Undefined: no watchdog logic; STORE and RELEASE wait indefinitely.

Decomposition:
- Shared package (lsu_pkg) holds:
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD.
  - mem write codes WR_NONE, WR_BYTE, WR_HALF, WR_WORD.
  - the FSM state encoding.
- One natural sub-module: lsu_load_extend. It is combinational: size, signed and q0..q3 in; 32-bit result out.
- Lane packing stays inline.

Test Plan:
- Word store: addr=0x10, wdata=0xDEADBEEF.
  - Expect mem_write=3, d0..d3=DE,AD,BE,EF, held until mem_done.
  - Expect mem_write=0 until mem_done falls, then one resp_valid with fault=0.
- Signed byte load: addr=0x20, model q0=0x80.
  - Expect resp_rdata=0xFFFFFF80 exactly READ_LATENCY+2 cycles after accept.
  - Unsigned repeat expects 0x00000080.
- Half load: addr=0x24, q0=0x12, q1=0xF4, signed.
  - Expect 0x000012F4.
  - With q0=0x92: expect 0xFFFF92F4.
- Misaligned store: addr=0x13.
  - mem_write never leaves 0.
  - resp_valid with resp_fault=1 two cycles after accept.
- Reset mid-store: assert rst_n=0 while in STORE.
  - mem_write=0 and req_ready=1 immediately.
  - No resp_valid is produced.
  - A new load after release completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8, memory never asserts mem_done.
  - resp_fault=1 with mem_write=0 once the watchdog reaches 8 in STORE.
